fx2_fifo_reader: RTL

//  Host->FPGA path: reads 16-bit words from the FX2 slave FIFO (sync mode, IFCLK domain), pairs them

---
 rtl/fx2_pkg.sv | 12 +
 rtl/fx2_fifo_reader_if.sv | 15 +
 rtl/fx2_skid2.sv | 52 +++++
 rtl/fx2_fifo_reader.sv | 90 +++++++++
 4 files changed

// File: rtl/fx2_pkg.sv
// Shared FX2 slave-FIFO definitions: word width, strobe timing defaults and reader FSM states.
package fx2_pkg;
  localparam int FX2_W        = 16;
  localparam int FLAG_LAT_DEF = 3;
  localparam int OE_SETUP_DEF = 1;

  typedef logic [2*FX2_W-1:0] fx2_word_t;

  typedef enum logic [2:0] {
    S_IDLE, S_OE, S_RD_LO, S_WT_LO, S_RD_HI, S_WT_HI
  } fx2_rd_state_t;
endpackage

// File: rtl/fx2_fifo_reader_if.sv
// FX2 read-side bus plus the assembled 32-bit output stream.
interface fx2_fifo_reader_if;
  import fx2_pkg::*;

  logic [FX2_W-1:0]   fd_i;
  logic               flag_ne;
  logic               sloe_n;
  logic               slrd_n;
  logic [2*FX2_W-1:0] m_data;
  logic               m_valid;
  logic               m_ready;

  modport master (input fd_i, flag_ne, m_ready, output sloe_n, slrd_n, m_data, m_valid);
  modport slave  (output fd_i, flag_ne, m_ready, input sloe_n, slrd_n, m_data, m_valid);
endinterface

// File: rtl/fx2_skid2.sv
// Two-entry valid/ready buffer for assembled words; reports free entries to the reader FSM.
module fx2_skid2 import fx2_pkg::*; (
  input  logic      clk,
  input  logic      reset,
  input  logic      push_i,
  input  fx2_word_t data_i,
  input  logic      pop_i,
  output fx2_word_t data_o,
  output logic      valid_o,
  output logic [1:0] free_o
);
  fx2_word_t  head_q, tail_q;
  logic [1:0] cnt_q;
  logic       pop;

  assign pop     = pop_i && (cnt_q != 2'd0);
  assign data_o  = head_q;
  assign valid_o = (cnt_q != 2'd0);
  assign free_o  = 2'd2 - cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      case ({push_i, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= data_i;
          else               tail_q <= data_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd2) head_q <= tail_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; the new word lands behind whatever remains
          if (cnt_q == 2'd1) head_q <= data_i;
          else begin
            head_q <= tail_q;
            tail_q <= data_i;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push_i && !pop && cnt_q == 2'd2));
endmodule

// File: rtl/fx2_fifo_reader.sv
// Reads 16-bit words from the FX2 OUT FIFO and pairs them (low half first) into a 32-bit stream.
module fx2_fifo_reader import fx2_pkg::*; #(
  parameter int FLAG_LAT = FLAG_LAT_DEF,  // 1..256
  parameter int OE_SETUP = OE_SETUP_DEF,  // 1..256
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  fx2_fifo_reader_if.master bus,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              busy
);
  fx2_rd_state_t    state_q;
  logic [7:0]       tmr_q;
  logic [FX2_W-1:0] lo_q;
  logic             sloe_n_q, busy_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [1:0]       free;
  logic             strobe, push, pop, room;

  // The strobe has to follow flag_ne in the same cycle, so it is decoded from the state register.
  assign strobe = ((state_q == S_RD_LO) || (state_q == S_RD_HI)) && bus.flag_ne;
  assign push   = (state_q == S_RD_HI) && bus.flag_ne;
  assign pop    = bus.m_valid && bus.m_ready;
  assign room   = (free != 2'd0);

  assign bus.slrd_n = ~strobe;
  assign bus.sloe_n = sloe_n_q;
  assign busy       = busy_q;
  assign word_cnt   = word_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      lo_q     <= '0;
      sloe_n_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.flag_ne && room) begin
          state_q  <= S_OE;
          sloe_n_q <= 1'b0;
          busy_q   <= 1'b1;
          tmr_q    <= 8'(OE_SETUP - 1);
        end
        S_OE: if (tmr_q == 8'd0) state_q <= S_RD_LO;
              else               tmr_q   <= tmr_q - 8'd1;
        S_RD_LO: if (bus.flag_ne) begin
          lo_q    <= bus.fd_i;
          tmr_q   <= 8'(FLAG_LAT - 1);
          state_q <= S_WT_LO;
        end
        S_WT_LO: if (tmr_q == 8'd0) state_q <= S_RD_HI;
                 else               tmr_q   <= tmr_q - 8'd1;
        S_RD_HI: if (bus.flag_ne) begin
          tmr_q   <= 8'(FLAG_LAT - 1);
          state_q <= S_WT_HI;
        end
        S_WT_HI: if (tmr_q != 8'd0) tmr_q <= tmr_q - 8'd1;
        else if (bus.flag_ne && room) state_q <= S_RD_LO;
        else begin
          state_q  <= S_IDLE;
          sloe_n_q <= 1'b1;
          busy_q   <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)    word_cnt_q <= '0;
    else if (pop) word_cnt_q <= word_cnt_q + CNT_W'(1);
  end

  fx2_skid2 u_skid (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  ({bus.fd_i, lo_q}),
    .pop_i   (pop),
    .data_o  (bus.m_data),
    .valid_o (bus.m_valid),
    .free_o  (free)
  );

  a_strobe_oe:  assert property (@(posedge clk) disable iff (reset) !(strobe && sloe_n_q));
  a_strobe_gap: assert property (@(posedge clk) disable iff (reset) strobe |=> !strobe);
endmodule
